// File: rtl/uart_param_bridge.sv
// uart_param_bridge: framed command/response bridge from a UART byte stream to per-channel waveform parameters.
// Ports:
//   clk, reset (async, active-low)
//   rx_data/rx_valid/rx_error/rx_ready : request byte stream from the UART receiver
//   tx_data/tx_valid/tx_error/tx_ready : response byte stream to the UART transmitter
//   signal_number/adder/amplitude      : per-channel parameter registers, channel c in slice c
//   signal                             : per-channel live samples, captured for readback
//   update_strobe                      : one-cycle pulse on the channel whose parameter is written
//   frame_err                          : one-cycle pulse when a frame is dropped
module uart_param_bridge #(
    parameter int NUM_CH = 4,
    parameter int DATA_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CYC = 1_000_000,
    localparam int DW = 8 * DATA_BYTES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_error,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 tx_error,
    input  logic                 tx_ready,
    output logic [NUM_CH*8-1:0]  signal_number,
    output logic [NUM_CH*DW-1:0] adder,
    output logic [NUM_CH*DW-1:0] amplitude,
    input  logic [NUM_CH*DW-1:0] signal,
    output logic [NUM_CH-1:0]    update_strobe,
    output logic                 frame_err
);
    localparam int RL = DATA_BYTES + 3;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_CH, S_DATA, S_CSUM, S_EXEC, S_RESP} state_t;
    state_t state, state_nx;

    logic          live;
    logic [7:0]    cmd_r, ch_r, acc_r, csum_r, bcnt, len_r, rcsum;
    logic [DW-1:0] data_r, rd_word;
    logic [TW-1:0] tmo;
    logic [8*RL-1:0] buf_r;
    logic [7:0]    sn_r [NUM_CH];
    logic [DW-1:0] add_r [NUM_CH];
    logic [DW-1:0] amp_r [NUM_CH];
    logic          in_rx, rx_fire, tx_fire, drop, is_wr, ok, wr;

    assign in_rx   = state inside {S_CMD, S_CH, S_DATA, S_CSUM};
    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    assign drop    = (state != S_IDLE && rx_valid && rx_error) || (in_rx && tmo == TW'(TIMEOUT_CYC));
    assign is_wr   = cmd_r inside {8'h01, 8'h02, 8'h03};
    assign ok      = (acc_r == csum_r) && (32'(ch_r) < 32'(NUM_CH)) && (is_wr || cmd_r == 8'h10);
    assign wr      = state == S_EXEC && ok && is_wr;
    assign rd_word = DW'(signal >> (DW * 32'(ch_r)));
    assign tx_error = 1'b0;

    always_comb begin
        rcsum = cmd_r;
        for (int i = 0; i < DATA_BYTES; i++) rcsum = rcsum ^ rd_word[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (drop) state_nx = S_IDLE;
        else begin
            case (state)
                S_IDLE:  state_nx = (rx_fire && !rx_error && rx_data == SYNC_BYTE) ? S_CMD : S_IDLE;
                S_CMD:   state_nx = rx_fire ? S_CH : S_CMD;
                S_CH:    state_nx = rx_fire ? S_DATA : S_CH;
                S_DATA:  state_nx = (rx_fire && bcnt == 8'(DATA_BYTES - 1)) ? S_CSUM : S_DATA;
                S_CSUM:  state_nx = rx_fire ? S_EXEC : S_CSUM;
                S_EXEC:  state_nx = S_RESP;
                S_RESP:  state_nx = (tx_fire && len_r == 8'd1) ? S_IDLE : S_RESP;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready      = live && (state == S_IDLE || in_rx);
        tx_valid      = state == S_RESP;
        tx_data       = tx_valid ? buf_r[8*RL-1 -: 8] : 8'h00;
        frame_err     = drop;
        update_strobe = wr ? (NUM_CH'(1) << ch_r) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live   <= 1'b0;
            cmd_r  <= '0;
            ch_r   <= '0;
            acc_r  <= '0;
            csum_r <= '0;
            bcnt   <= '0;
            len_r  <= '0;
            data_r <= '0;
            tmo    <= '0;
            buf_r  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sn_r[c]  <= '0;
                add_r[c] <= '0;
                amp_r[c] <= '0;
            end
        end else begin
            live <= 1'b1;
            // Idle-cycle counter only runs while a frame is in progress.
            tmo  <= (in_rx && !rx_fire) ? tmo + 1'b1 : '0;
            if (rx_fire) begin
                if (state == S_CMD) begin
                    cmd_r <= rx_data;
                    acc_r <= rx_data;
                end
                if (state == S_CH) begin
                    ch_r  <= rx_data;
                    acc_r <= acc_r ^ rx_data;
                    bcnt  <= '0;
                end
                if (state == S_DATA) begin
                    data_r <= (data_r << 8) | DW'(rx_data);
                    acc_r  <= acc_r ^ rx_data;
                    bcnt   <= bcnt + 8'd1;
                end
                if (state == S_CSUM) csum_r <= rx_data;
            end
            // The response is built as a shift register; a NAK just sends its first two bytes.
            if (state == S_EXEC) begin
                len_r <= (ok && cmd_r == 8'h10) ? 8'(RL) : 8'd2;
                buf_r <= {ok ? 8'h06 : 8'h15, cmd_r, rd_word, rcsum};
            end else if (tx_fire) begin
                len_r <= len_r - 8'd1;
                buf_r <= buf_r << 8;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr && ch_r == 8'(c) && cmd_r == 8'h01) sn_r[c]  <= data_r[7:0];
                if (wr && ch_r == 8'(c) && cmd_r == 8'h02) add_r[c] <= data_r;
                if (wr && ch_r == 8'(c) && cmd_r == 8'h03) amp_r[c] <= data_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign signal_number[8*g +: 8] = sn_r[g];
        assign adder[DW*g +: DW]       = add_r[g];
        assign amplitude[DW*g +: DW]   = amp_r[g];
    end
endmodule

// File: tb/tb_uart_param_bridge.sv
// tb_uart_param_bridge: directed self-checking bench for uart_param_bridge.
module tb_uart_param_bridge;
    localparam int NC = 4;
    localparam int T  = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_error = 1'b0;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_error;
    logic         tx_ready = 1'b0;
    logic [NC*8-1:0]  signal_number;
    logic [NC*32-1:0] adder;
    logic [NC*32-1:0] amplitude;
    logic [NC*32-1:0] signal = '0;
    logic [NC-1:0]    update_strobe;
    logic             frame_err;

    int total = 0;
    int bad = 0;

    uart_param_bridge #(.NUM_CH(NC), .DATA_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_error(tx_error), .tx_ready(tx_ready),
        .signal_number(signal_number), .adder(adder), .amplitude(amplitude), .signal(signal),
        .update_strobe(update_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", rx_ready, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ch, input logic [31:0] d, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(ch);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(cs);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {tx_valid, tx_data}, {1'b1, exp});
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic stable;
        logic [7:0] d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_signal_number", signal_number, '0);
        check("rst_adder", adder, '0);
        check("rst_amplitude", amplitude, '0);
        check("rst_tx", {tx_valid, tx_data, tx_error}, '0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_pulses", {update_strobe, frame_err}, '0);
        reset = 1'b1;
        #1;
        check("rx_ready_before_edge", rx_ready, 1'b0);
        @(posedge clk); #1;
        check("rx_ready_after_edge", rx_ready, 1'b1);

        // write adder ch1
        send_frame(8'h02, 8'h01, 32'h0001_0000, 8'h02);
        check("wr_strobe_exec", update_strobe, 4'b0010);
        check("wr_rx_ready_exec", rx_ready, 1'b0);
        check("wr_adder_not_yet", adder, '0);
        recv_byte("wr_ack0", 8'h06);
        recv_byte("wr_ack1", 8'h02);
        check("wr_adder", adder, {32'h0, 32'h0, 32'h0001_0000, 32'h0});
        check("wr_strobe_gone", update_strobe, 4'b0000);

        // sync value as data is ordinary
        send_frame(8'h02, 8'h00, 32'hA5A5_A5A5, 8'h02);
        recv_byte("a5_ack0", 8'h06);
        recv_byte("a5_ack1", 8'h02);
        check("a5_adder", adder, {32'h0, 32'h0, 32'h0001_0000, 32'hA5A5_A5A5});

        // read ch0, sample changes after capture
        signal[31:0] = 32'h1234_5678;
        send_frame(8'h10, 8'h00, 32'h0, 8'h10);
        recv_byte("rd_b0", 8'h06);
        signal[31:0] = 32'hDEAD_BEEF;
        recv_byte("rd_b1", 8'h10);
        recv_byte("rd_b2", 8'h12);
        recv_byte("rd_b3", 8'h34);
        recv_byte("rd_b4", 8'h56);
        recv_byte("rd_b5", 8'h78);
        recv_byte("rd_b6", 8'h18);

        // channel out of range
        send_frame(8'h03, 8'h04, 32'h5, 8'h02);
        check("badch_strobe", update_strobe, 4'b0000);
        recv_byte("badch_nak0", 8'h15);
        recv_byte("badch_nak1", 8'h03);
        // checksum error
        send_frame(8'h03, 8'h00, 32'h5, 8'h07);
        check("badcs_strobe", update_strobe, 4'b0000);
        recv_byte("badcs_nak0", 8'h15);
        recv_byte("badcs_nak1", 8'h03);
        check("badcs_amplitude", amplitude, '0);
        // unknown command
        send_frame(8'h07, 8'h00, 32'h0, 8'h07);
        recv_byte("badcmd_nak0", 8'h15);
        recv_byte("badcmd_nak1", 8'h07);

        // inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h02);
        n = 0;
        while (!frame_err && n < 3 * T) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", n, T);
        check("timeout_no_tx", tx_valid, 1'b0);
        @(posedge clk); #1;
        check("timeout_pulse_len", frame_err, 1'b0);
        send_frame(8'h01, 8'h02, 32'h3, 8'h00);
        recv_byte("sn_ack0", 8'h06);
        recv_byte("sn_ack1", 8'h01);
        check("sn_value", signal_number, 32'h0003_0000);

        // rx_error mid-frame drops it; in IDLE it is silent
        send_byte(8'hA5);
        send_byte(8'h01);
        rx_data = 8'h33; rx_valid = 1'b1; rx_error = 1'b1;
        #1;
        check("rxerr_frame_err", frame_err, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_error = 1'b0;
        check("rxerr_pulse_len", frame_err, 1'b0);
        rx_data = 8'hA5; rx_valid = 1'b1; rx_error = 1'b1;
        #1;
        check("idle_rxerr_silent", frame_err, 1'b0);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_error = 1'b0;

        // stalled read response, then reset mid-response
        signal[127:96] = 32'hCAFE_BABE;
        send_frame(8'h10, 8'h03, 32'h0, 8'h13);
        @(posedge clk); #1;
        d0 = tx_data;
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (tx_data !== d0 || tx_valid !== 1'b1 || rx_ready !== 1'b0) stable = 1'b0;
        end
        check("stall_stable", stable, 1'b1);
        recv_byte("st_b0", 8'h06);
        recv_byte("st_b1", 8'h10);
        recv_byte("st_b2", 8'hCA);
        reset = 1'b0;
        #1;
        check("midrst_tx", {tx_valid, tx_data}, '0);
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_params", {signal_number, adder, amplitude}, '0);
        check("midrst_pulses", {update_strobe, frame_err}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // leading garbage then write amplitude ch3
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(8'h03, 8'h03, 32'h1122_3344, 8'h44);
        check("garb_strobe", update_strobe, 4'b1000);
        recv_byte("garb_ack0", 8'h06);
        recv_byte("garb_ack1", 8'h03);
        check("garb_amplitude", amplitude, {32'h1122_3344, 96'h0});
        tx_ready = 1'b1;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (tx_valid !== 1'b0) stable = 1'b0;
        end
        tx_ready = 1'b0;
        check("garb_single_ack", stable, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
